// File: rtl/framebuffer_if.sv
// framebuffer_if: pixel port and scanout port of the framebuffer.
//   Pixel port : x_b, y_b, read_b, write_b, in_b (to store); out_b, rdy_b (from store)
//   Scanout    : scan_req, scan_addr (to store); scan_data, scan_valid (from store)
//   master = command processor / video side, slave = framebuffer.
interface framebuffer_if;
    logic [8:0]  x_b;
    logic [7:0]  y_b;
    logic        read_b;
    logic        write_b;
    logic        in_b;
    logic        out_b;
    logic        rdy_b;
    logic        scan_req;
    logic [12:0] scan_addr;
    logic [7:0]  scan_data;
    logic        scan_valid;

    modport master (
        output x_b, y_b, read_b, write_b, in_b, scan_req, scan_addr,
        input  out_b, rdy_b, scan_data, scan_valid
    );

    modport slave (
        input  x_b, y_b, read_b, write_b, in_b, scan_req, scan_addr,
        output out_b, rdy_b, scan_data, scan_valid
    );
endinterface

// File: rtl/framebuffer.sv
// framebuffer: single-port 1-bpp pixel store (WIDTH x HEIGHT pixels, BYTES bytes).
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (memory contents are kept)
//   bus  : framebuffer_if.slave
//          pixel port  - one-cycle read_b/write_b pulses, rdy_b level handshake,
//                        writes are read-modify-write of the containing byte
//          scanout     - scan_req reads scan_addr, scan_data/scan_valid one cycle later
// Scanout always owns the memory port; the pixel FSM stalls in RD/WB while scan_req=1.
module framebuffer #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 200,
    parameter int unsigned BYTES  = 8000
) (
    input logic          clk,
    input logic          rst,
    framebuffer_if.slave bus
);
    localparam int unsigned ROW_BYTES = WIDTH / 8;

    typedef enum logic [1:0] {IDLE, RD, LATCH, WB} state_t;

    state_t      state;
    logic [12:0] addr_q;
    logic [2:0]  bit_q;
    logic        din_q;
    logic        op_wr_q;
    logic        ok_q;
    logic [7:0]  mod_q;
    logic        rdy_q;
    logic        out_q;

    logic [7:0]  rd_q;
    logic        scan_valid_q;
    logic        scan_zero_q;
    logic [7:0]  scan_hold_q;

    // Configuration-time contents are all zero; rst does not touch them.
    logic [7:0]  mem [BYTES] = '{default: 8'h00};

    logic        req_ok;
    logic [12:0] req_addr;
    logic        scan_ok;
    logic [7:0]  merged;
    logic [7:0]  scan_out;
    logic        port_rd;
    logic        port_we;
    logic [12:0] port_addr;

    assign req_ok   = (32'(bus.x_b) < WIDTH) && (32'(bus.y_b) < HEIGHT);
    assign req_addr = 13'((32'(bus.y_b) * ROW_BYTES) + 32'(bus.x_b[8:3]));
    assign scan_ok  = 32'(bus.scan_addr) < BYTES;

    // Fetched byte with the captured pixel substituted at the captured bit.
    always_comb begin
        merged        = ok_q ? rd_q : 8'h00;
        merged[bit_q] = din_q;
    end

    // Single memory port: scanout wins; out-of-range pixel ops never strobe.
    always_comb begin
        port_addr = addr_q;
        port_rd   = 1'b0;
        port_we   = 1'b0;
        if (bus.scan_req) begin
            port_addr = bus.scan_addr;
            port_rd   = scan_ok;
        end else begin
            port_rd = (state == RD) && ok_q;
            port_we = (state == WB) && op_wr_q && ok_q;
        end
    end

    always_ff @(posedge clk) begin
        if (port_we && !rst) begin
            mem[port_addr] <= mod_q;
        end
        if (port_rd) begin
            rd_q <= mem[port_addr];
        end
    end

    // Scanout result register; scan_hold_q keeps the last valid byte on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_valid_q <= 1'b0;
            scan_zero_q  <= 1'b0;
            scan_hold_q  <= 8'h00;
        end else begin
            scan_valid_q <= bus.scan_req;
            scan_zero_q  <= bus.scan_req && !scan_ok;
            if (scan_valid_q) begin
                scan_hold_q <= scan_out;
            end
        end
    end

    assign scan_out       = scan_zero_q ? 8'h00 : rd_q;
    assign bus.scan_data  = scan_valid_q ? scan_out : scan_hold_q;
    assign bus.scan_valid = scan_valid_q;

    // Pixel FSM; rdy_b drops on the same edge that samples the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdy_q   <= 1'b1;
            out_q   <= 1'b0;
            addr_q  <= '0;
            bit_q   <= '0;
            din_q   <= 1'b0;
            op_wr_q <= 1'b0;
            ok_q    <= 1'b0;
            mod_q   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.write_b || bus.read_b) begin
                        addr_q  <= req_ok ? req_addr : 13'd0;
                        bit_q   <= bus.x_b[2:0];
                        din_q   <= bus.in_b;
                        op_wr_q <= bus.write_b;
                        ok_q    <= req_ok;
                        rdy_q   <= 1'b0;
                        state   <= RD;
                    end
                end
                RD: begin
                    if (!bus.scan_req) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    if (op_wr_q) begin
                        mod_q <= merged;
                        state <= WB;
                    end else begin
                        out_q <= ok_q & rd_q[bit_q];
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                WB: begin
                    if (!bus.scan_req) begin
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdy_b = rdy_q;
    assign bus.out_b = out_q;
endmodule

// File: tb/tb_framebuffer.sv
// tb_framebuffer: randomized self-checking bench for framebuffer.
// A byte-array model of the pixel store predicts pixel reads, scanout bytes
// and completion times (a read needs one free memory slot then a latch cycle,
// a write additionally needs a second free slot for write-back).
module tb_framebuffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    framebuffer_if bus ();

    framebuffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0] model [8000];
    logic [7:0] last_scan;
    logic       exp_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] model_byte(input int a);
        return (a < 8000) ? model[a] : 8'h00;
    endfunction

    function automatic logic model_pix(input int x, input int y);
        logic [7:0] b;
        if (x >= 320 || y >= 200) return 1'b0;
        b = model[y * 40 + x / 8];
        return b[x % 8];
    endfunction

    // One clock; checks scanout against the model with one-cycle latency.
    task automatic tick();
        logic       exp_v;
        logic [7:0] exp_d;
        exp_v = bus.scan_req;
        exp_d = exp_v ? model_byte(int'(bus.scan_addr)) : last_scan;
        @(posedge clk);
        #1;
        check("scan_valid", bus.scan_valid, exp_v);
        check("scan_data", bus.scan_data, exp_d);
        last_scan = exp_d;
    endtask

    task automatic set_scan(input int pct);
        bus.scan_req  = ($urandom_range(99) < pct);
        bus.scan_addr = ($urandom_range(9) == 0) ? 13'($urandom_range(8191))
                                                 : 13'($urandom_range(7999));
    endtask

    task automatic probe(input int a, input logic [7:0] exp, input string tag);
        bus.scan_req  = 1'b1;
        bus.scan_addr = 13'(a);
        tick();
        check(tag, bus.scan_data, exp);
        bus.scan_req = 1'b0;
    endtask

    // Issue one pixel request and follow it to completion.
    // hold_wb: cycles of forced scan_req once the write is in write-back.
    // dup: pulse a second (conflicting) write on the first busy cycle.
    task automatic pixel_op(input bit wr, input bit rd, input int x, input int y, input bit v,
                            input int pct, input int hold_wb, input bit dup, output int lat);
        int need[$];
        int pi;
        int hold;
        logic [7:0] b;
        hold         = hold_wb;
        bus.x_b      = 9'(x);
        bus.y_b      = 8'(y);
        bus.write_b  = wr;
        bus.read_b   = rd;
        bus.in_b     = v;
        set_scan(pct);
        tick();
        bus.write_b = 1'b0;
        bus.read_b  = 1'b0;
        check("rdy_fall", bus.rdy_b, 1'b0);
        if (wr) need = '{1, 0, 1};
        else    need = '{1, 0};
        pi  = 0;
        lat = 1;
        while (pi < need.size() && lat < 200) begin
            if (hold > 0 && pi == 2) begin
                bus.scan_req  = 1'b1;
                bus.scan_addr = (hold == hold_wb) ? 13'd8191 : 13'($urandom_range(7999));
                hold--;
            end else begin
                set_scan(pct);
            end
            if (dup && lat == 1) begin
                bus.write_b = 1'b1;
                bus.in_b    = ~v;
                bus.x_b     = 9'(x ^ 1);
            end
            if (need[pi] == 0 || !bus.scan_req) pi++;
            tick();
            lat++;
            bus.write_b = 1'b0;
            if (pi < need.size()) check("busy", bus.rdy_b, 1'b0);
        end
        check("rdy_done", bus.rdy_b, 1'b1);
        if (wr) begin
            if (x < 320 && y < 200) begin
                b = model[y * 40 + x / 8];
                b[x % 8] = v;
                model[y * 40 + x / 8] = b;
            end
        end else begin
            exp_out = model_pix(x, y);
        end
        check("out_b", bus.out_b, exp_out);
        bus.scan_req = 1'b0;
    endtask

    initial begin
        int lat;
        bit vals[8];
        for (int i = 0; i < 8000; i++) model[i] = 8'h00;
        last_scan     = 8'h00;
        exp_out       = 1'b0;
        rst           = 1'b1;
        bus.x_b       = '0;
        bus.y_b       = '0;
        bus.read_b    = 1'b0;
        bus.write_b   = 1'b0;
        bus.in_b      = 1'b0;
        bus.scan_req  = 1'b0;
        bus.scan_addr = '0;
        #12;
        check("rst_rdy", bus.rdy_b, 1'b1);
        check("rst_out", bus.out_b, 1'b0);
        check("rst_sv", bus.scan_valid, 1'b0);
        check("rst_sd", bus.scan_data, 8'h00);
        rst = 1'b0;
        tick();

        // Round trip at (5,3).
        pixel_op(1, 0, 5, 3, 1, 0, 0, 0, lat);
        check("rt_wlat", lat, 4);
        probe(120, 8'h20, "rt_byte");
        pixel_op(0, 1, 5, 3, 0, 0, 0, 0, lat);
        check("rt_rlat", lat, 3);
        check("rt_out", bus.out_b, 1'b1);

        // Neighbour preservation in byte 1.
        vals = '{1, 0, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) pixel_op(1, 0, 8 + i, 0, vals[i], 0, 0, 0, lat);
        probe(1, 8'h4D, "nb_byte0");
        pixel_op(1, 0, 9, 0, 1, 0, 0, 0, lat);
        probe(1, 8'h4F, "nb_byte1");

        // Out of range.
        pixel_op(1, 0, 320, 0, 1, 0, 0, 0, lat);
        check("oor_lat_x", lat, 4);
        pixel_op(1, 0, 0, 200, 1, 0, 0, 0, lat);
        check("oor_lat_y", lat, 4);
        probe(40, 8'h00, "oor_byte40");
        probe(0, 8'h00, "oor_byte0");
        pixel_op(1, 0, 319, 199, 1, 0, 0, 0, lat);
        probe(7999, 8'h80, "corner_byte");
        pixel_op(0, 1, 319, 199, 0, 0, 0, 0, lat);
        check("corner_out", bus.out_b, 1'b1);
        pixel_op(0, 1, 320, 5, 0, 0, 0, 0, lat);
        check("oor_rlat", lat, 3);
        check("oor_out", bus.out_b, 1'b0);

        // Scan contention during write-back.
        pixel_op(1, 0, 20, 20, 1, 0, 5, 0, lat);
        check("wb_stall_lat", lat, 9);
        probe(8191, 8'h00, "scan_oob");
        probe(20 * 40 + 2, 8'h10, "wb_stall_byte");

        // Request rules.
        pixel_op(1, 1, 40, 10, 1, 0, 0, 0, lat);
        check("both_lat", lat, 4);
        pixel_op(0, 1, 40, 10, 0, 0, 0, 0, lat);
        check("both_out", bus.out_b, 1'b1);
        pixel_op(1, 0, 50, 10, 0, 0, 0, 1, lat);
        probe(406, 8'h00, "dup_byte");

        // Reset while in write-back: byte keeps its old value.
        bus.x_b     = 9'd100;
        bus.y_b     = 8'd50;
        bus.in_b    = 1'b1;
        bus.write_b = 1'b1;
        tick();
        bus.write_b = 1'b0;
        tick();
        tick();
        bus.scan_req  = 1'b1;
        bus.scan_addr = 13'd2012;
        tick();
        check("wb_busy", bus.rdy_b, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rdy", bus.rdy_b, 1'b1);
        check("mid_rst_out", bus.out_b, 1'b0);
        check("mid_rst_sv", bus.scan_valid, 1'b0);
        bus.scan_req = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        last_scan = 8'h00;
        exp_out   = 1'b0;
        probe(2012, 8'h00, "mid_rst_byte");
        pixel_op(0, 1, 100, 50, 0, 0, 0, 0, lat);
        check("mid_rst_rlat", lat, 3);

        // Randomized traffic with random scanout contention.
        for (int k = 0; k < 80; k++) begin
            int rx;
            int ry;
            bit w;
            w = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) begin
                rx = $urandom_range(330);
                ry = $urandom_range(205);
            end else begin
                rx = $urandom_range(15);
                ry = $urandom_range(3);
            end
            pixel_op(w, !w, rx, ry, 1'($urandom_range(1)), 35, 0, 0, lat);
        end
        for (int a = 0; a < 8; a++) probe(a, model_byte(a), "final_sweep");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
